maze_path_replay: RTL and testbench

- Downstream stage of the maze-search controller. Holds the direction stack that the controller pushes and pops while searching and backtracking.
- Once the controller signals run, replays the stored path from the start cell to the goal cell, one move per handshake.
- Tracks the rat's (i,j) coordinate for the display/output logic.
- Supplies the controller's top-of-stack direction (fStackRes), used to pick the backtrack branch.

---
 rtl/maze_path_replay.sv | 223 ++++++++++++++++++++++
 tb/tb_maze_path_replay.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_path_replay.sv
// maze_path_replay: direction stack for the maze-search controller, plus an
// in-order replay of the stored path with (i,j) position tracking.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  BUILD  | push/pop accepted; top_dir follows the stack top
//  REPLAY | stored moves presented oldest-first, one per handshake
//  DONE   | replay finished (or empty path); holds until RST
module maze_path_replay #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int COORD_W = 4,
    parameter int START_I = 0,
    parameter int START_J = 0
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               push,
    input  logic               pop,
    input  logic [1:0]         dir_in,
    output logic [1:0]         top_dir,
    output logic               empty,
    output logic               full,
    output logic               err,
    input  logic               run,
    output logic               move_valid,
    output logic [1:0]         move,
    input  logic               move_ready,
    output logic [COORD_W-1:0] pos_i,
    output logic [COORD_W-1:0] pos_j,
    output logic               busy,
    output logic               done_show
);

    typedef enum logic [1:0] {
        BUILD  = 2'd0,
        REPLAY = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    // sp counts 0..DEPTH, so it needs one bit more than the read pointer
    localparam logic [AW:0]        SP_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]        SP_ONE    = (AW+1)'(1);
    localparam logic [AW:0]        SP_TWO    = (AW+1)'(2);
    localparam logic [COORD_W-1:0] POS_ONE   = COORD_W'(1);
    localparam logic [COORD_W-1:0] POS_I_RST = COORD_W'(START_I);
    localparam logic [COORD_W-1:0] POS_J_RST = COORD_W'(START_J);

    logic [1:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [AW:0]        sp_q, sp_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [1:0]         top_q, top_d;
    logic               err_q, err_d;
    logic               mv_q, mv_d;
    logic [1:0]         move_q, move_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [COORD_W-1:0] pos_i_q, pos_i_d;
    logic [COORD_W-1:0] pos_j_q, pos_j_d;

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [1:0]         wr_data;

    logic               empty_w;
    logic               full_w;
    logic [AW:0]        sp_m1;
    logic [AW:0]        sp_m2;
    logic [AW-1:0]      rd_p1;

    assign empty_w = (sp_q == '0);
    assign full_w  = (sp_q == SP_FULL);
    assign sp_m1   = sp_q - SP_ONE;
    assign sp_m2   = sp_q - SP_TWO;
    assign rd_p1   = rd_q + AW'(1);

    // Stack storage; contents deliberately not reset, writes blocked during reset
    always_ff @(posedge clk) begin
        if (!RST && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State and control registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= BUILD;
            sp_q    <= '0;
            rd_q    <= '0;
            top_q   <= 2'b00;
            err_q   <= 1'b0;
            mv_q    <= 1'b0;
            move_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pos_i_q <= POS_I_RST;
            pos_j_q <= POS_J_RST;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            rd_q    <= rd_d;
            top_q   <= top_d;
            err_q   <= err_d;
            mv_q    <= mv_d;
            move_q  <= move_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pos_i_q <= pos_i_d;
            pos_j_q <= pos_j_d;
        end
    end

    // Next-state: stack ops in BUILD, handshake-driven replay, terminal DONE
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        rd_d    = rd_q;
        top_d   = top_q;
        err_d   = err_q;
        mv_d    = mv_q;
        move_d  = move_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pos_i_d = pos_i_q;
        pos_j_d = pos_j_q;
        wr_en   = 1'b0;
        wr_addr = sp_q[AW-1:0];
        wr_data = dir_in;

        case (state_q)
            BUILD: begin
                // push+pop on an empty stack degrades to a plain push
                if (push && (!pop || empty_w)) begin
                    if (!full_w) begin
                        wr_en   = 1'b1;
                        wr_addr = sp_q[AW-1:0];
                        sp_d    = sp_q + SP_ONE;
                        top_d   = dir_in;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (push && pop) begin
                    wr_en   = 1'b1;
                    wr_addr = sp_m1[AW-1:0];
                    top_d   = dir_in;
                end else if (pop) begin
                    if (!empty_w) begin
                        sp_d  = sp_m1;
                        top_d = (sp_q >= SP_TWO) ? mem[sp_m2[AW-1:0]] : 2'b00;
                    end else begin
                        err_d = 1'b1;
                    end
                end

                // run sees the stack as updated by this cycle's operation
                if (run) begin
                    if (sp_d == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = REPLAY;
                        rd_d    = '0;
                        mv_d    = 1'b1;
                        busy_d  = 1'b1;
                        // bypass a same-cycle write to entry 0
                        move_d  = (wr_en && (wr_addr == '0)) ? wr_data : mem[0];
                    end
                end
            end

            REPLAY: begin
                if (mv_q && move_ready) begin
                    case (move_q)
                        DIR_UP:    pos_i_d = pos_i_q - POS_ONE;
                        DIR_DOWN:  pos_i_d = pos_i_q + POS_ONE;
                        DIR_LEFT:  pos_j_d = pos_j_q - POS_ONE;
                        DIR_RIGHT: pos_j_d = pos_j_q + POS_ONE;
                        default:   pos_i_d = pos_i_q;
                    endcase

                    if ({1'b0, rd_q} == sp_m1) begin
                        state_d = DONE;
                        mv_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rd_d   = rd_p1;
                        move_d = mem[rd_p1];
                    end
                end
            end

            DONE: begin
                mv_d   = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end

            default: begin
                state_d = BUILD;
            end
        endcase
    end

    assign top_dir    = top_q;
    assign empty      = empty_w;
    assign full       = full_w;
    assign err        = err_q;
    assign move_valid = mv_q;
    assign move       = move_q;
    assign pos_i      = pos_i_q;
    assign pos_j      = pos_j_q;
    assign busy       = busy_q;
    assign done_show  = done_q;

endmodule

// File: tb/tb_maze_path_replay.sv
// Directed bench for maze_path_replay: stack ops, replay handshake,
// position tracking, boundary and reset cases with hand-computed values.
module tb_maze_path_replay;

    logic       clk = 1'b0;
    logic       RST;
    logic       push;
    logic       pop;
    logic [1:0] dir_in;
    logic [1:0] top_dir;
    logic       empty;
    logic       full;
    logic       err;
    logic       run;
    logic       move_valid;
    logic [1:0] move;
    logic       move_ready;
    logic [3:0] pos_i;
    logic [3:0] pos_j;
    logic       busy;
    logic       done_show;

    int n_asserts = 0;
    int n_fails   = 0;

    maze_path_replay #(
        .DEPTH(256), .AW(8), .COORD_W(4), .START_I(0), .START_J(0)
    ) dut (
        .clk(clk), .RST(RST), .push(push), .pop(pop), .dir_in(dir_in),
        .top_dir(top_dir), .empty(empty), .full(full), .err(err),
        .run(run), .move_valid(move_valid), .move(move),
        .move_ready(move_ready), .pos_i(pos_i), .pos_j(pos_j),
        .busy(busy), .done_show(done_show)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; push = 1'b0; pop = 1'b0; run = 1'b0;
        dir_in = 2'b00; move_ready = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic push_dir(input logic [1:0] d);
        push = 1'b1; dir_in = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_top", top_dir, 0);
        chk("rst_mv", move_valid, 0);
        chk("rst_move", move, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_show, 0);
        chk("rst_pi", pos_i, 0);
        chk("rst_pj", pos_j, 0);

        // basic path 01,11,11,01 with move_ready high
        push_dir(2'b01); push_dir(2'b11); push_dir(2'b11); push_dir(2'b01);
        chk("t1_top", top_dir, 1);
        chk("t1_mv_before_run", move_valid, 0);
        move_ready = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t1_mv0", move_valid, 1);
        chk("t1_busy", busy, 1);
        chk("t1_move0", move, 1);
        chk("t1_pj0", pos_j, 0);
        tick();
        chk("t1_move1", move, 3);
        chk("t1_pi1", pos_i, 0);
        chk("t1_pj1", pos_j, 1);
        tick();
        chk("t1_move2", move, 3);
        chk("t1_pi2", pos_i, 1);
        tick();
        chk("t1_move3", move, 1);
        chk("t1_pi3", pos_i, 2);
        chk("t1_done_early", done_show, 0);
        tick();
        chk("t1_done", done_show, 1);
        chk("t1_mv_end", move_valid, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_pi_end", pos_i, 2);
        chk("t1_pj_end", pos_j, 2);
        push_dir(2'b10);
        chk("t1_frozen_top", top_dir, 1);
        chk("t1_frozen_pj", pos_j, 2);

        // pop sequence, underflow
        do_reset();
        push_dir(2'b00); push_dir(2'b01); push_dir(2'b10);
        do_pop();
        chk("t2_top_pop1", top_dir, 1);
        do_pop();
        chk("t2_top_pop2", top_dir, 0);
        chk("t2_empty_sp1", empty, 0);
        chk("t2_err0", err, 0);
        do_pop();
        chk("t2_empty", empty, 1);
        chk("t2_err_still0", err, 0);
        do_pop();
        chk("t2_err", err, 1);
        chk("t2_empty_after", empty, 1);

        // fill to DEPTH, overflow push
        do_reset();
        for (int i = 0; i < 255; i++) begin
            push_dir(2'(i));
        end
        chk("t3_full_255", full, 0);
        push_dir(2'b11);
        chk("t3_full", full, 1);
        chk("t3_top", top_dir, 3);
        push_dir(2'b00);
        chk("t3_err", err, 1);
        chk("t3_full_kept", full, 1);
        chk("t3_top_kept", top_dir, 3);

        // stalled replay: 11,01,00
        do_reset();
        push_dir(2'b11); push_dir(2'b01); push_dir(2'b00);
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 5; s++) begin
                tick();
                chk("t4_stall_mv", move_valid, 1);
                chk("t4_stall_move", move, (k == 0) ? 3 : (k == 1) ? 1 : 0);
                chk("t4_stall_pi", pos_i, (k == 0) ? 0 : 1);
                chk("t4_stall_pj", pos_j, (k == 2) ? 1 : 0);
            end
            chk("t4_done_pending", done_show, 0);
            move_ready = 1'b1;
            tick();
            move_ready = 1'b0;
        end
        chk("t4_done", done_show, 1);
        chk("t4_mv_end", move_valid, 0);
        chk("t4_pi_end", pos_i, 0);
        chk("t4_pj_end", pos_j, 1);

        // replace top; replay confirms [01,11]
        do_reset();
        push_dir(2'b01); push_dir(2'b00);
        push = 1'b1; pop = 1'b1; dir_in = 2'b11;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("t5_top", top_dir, 3);
        chk("t5_err", err, 0);
        move_ready = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t5_move0", move, 1);
        tick();
        chk("t5_move1", move, 3);
        tick();
        chk("t5_done", done_show, 1);
        chk("t5_pi", pos_i, 1);
        chk("t5_pj", pos_j, 1);

        // run on an empty stack
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t5_empty_done", done_show, 1);
        chk("t5_empty_mv", move_valid, 0);
        tick();
        chk("t5_empty_mv_later", move_valid, 0);

        // reset during the 2nd move
        do_reset();
        push_dir(2'b01); push_dir(2'b01); push_dir(2'b01);
        move_ready = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("t6_pj_mid", pos_j, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        move_ready = 1'b0;
        chk("t6_mv", move_valid, 0);
        chk("t6_pi", pos_i, 0);
        chk("t6_pj", pos_j, 0);
        chk("t6_empty", empty, 1);
        chk("t6_busy", busy, 0);
        push_dir(2'b11);
        chk("t6_push_top", top_dir, 3);
        chk("t6_push_empty", empty, 0);

        // push+pop on an empty stack acts as a push
        do_reset();
        push = 1'b1; pop = 1'b1; dir_in = 2'b10;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("t7_top", top_dir, 2);
        chk("t7_empty", empty, 0);
        chk("t7_err", err, 0);

        // run together with first push: replay uses the new entry; left wraps
        do_reset();
        push = 1'b1; dir_in = 2'b10; run = 1'b1;
        tick();
        push = 1'b0; run = 1'b0;
        chk("t8_mv", move_valid, 1);
        chk("t8_move", move, 2);
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        chk("t8_pj_wrap", pos_j, 15);
        chk("t8_done", done_show, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
